// File: rtl/usart_tx_pkg.sv
// Shared definitions for the 8N1 UART transmitter: FSM encoding, frame
// geometry and default parameters.
package usart_tx_pkg;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_BAUD_DIV   = 234;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter. Pointers carry one extra
// MSB so that full and empty are distinguished without a separate counter.
module usart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    // Head is read combinationally so the transmitter can load it on the pop edge.
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/usart_tx.sv
// UART transmitter, 8N1, LSB first. Bytes are queued through a valid/ready
// FIFO and serialised by a baud-tick FSM onto a registered serial line.
module usart_tx
    import usart_tx_pkg::*;
#(
    parameter int BaudRateDiv = DEFAULT_BAUD_DIV,
    parameter int FifoDepth   = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 usart_txp,
    output logic                 busy
);

    localparam int CntW    = cnt_width(BaudRateDiv);
    localparam int BitIdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0]    CntLast = CntW'(BaudRateDiv - 1);
    localparam logic [BitIdxW-1:0] BitLast = BitIdxW'(DATA_BITS - 1);

    tx_state_e              state_q;
    logic [CntW-1:0]        cnt_q;
    logic [BitIdxW-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   txp_q;
    logic                   busy_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   baud_wrap;

    usart_tx_fifo #(
        .Width (DATA_BITS),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_wrap = (cnt_q == CntLast);

    // Pop when idle, or at the end of a stop bit so the next frame follows without a gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_wrap));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txp_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        state_q <= ST_START;
                        txp_q   <= 1'b0;
                    end else begin
                        txp_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_wrap) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                        txp_q     <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_wrap) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == BitLast) begin
                            state_q <= ST_STOP;
                            txp_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + BitIdxW'(1);
                            txp_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_wrap) begin
                        cnt_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_rdata;
                            state_q <= ST_START;
                            txp_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            txp_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    txp_q   <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready  = !fifo_full;
    assign usart_txp = txp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx: a timeline model of frames and FIFO
// occupancy predicts line, ready and busy every cycle for two dividers.
module tb_usart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       v10 = 1'b0;
    logic       v2 = 1'b0;
    wire        r10, l10, b10;
    wire        r2, l2, b2;

    int passed = 0;
    int total  = 0;
    logic [7:0] stim_q[$];

    always #5 clk = ~clk;

    usart_tx #(.BaudRateDiv(10), .FifoDepth(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v10),
        .tx_ready(r10), .usart_txp(l10), .busy(b10)
    );

    usart_tx #(.BaudRateDiv(2), .FifoDepth(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(r2), .usart_txp(l2), .busy(b2)
    );

    // Bit j of a 10-bit 8N1 frame: start, data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Streams stim_q into one DUT and checks every cycle against the model.
    task automatic run_stream(input string name, input bit use2, input int gap_pct,
                              input int budget, output int stall_o);
        int div = use2 ? 2 : 10;
        int depth = 4;
        logic [7:0] pend[$];
        logic [7:0] fifo_m[$];
        logic [7:0] sent[$];
        logic [7:0] decoded[$];
        int cyc = 0;
        int cur_start = -1;
        logic [7:0] cur_byte = 8'h00;
        bit prev_nonidle = 1'b0;
        bit prev_nonempty = 1'b0;
        bit frame_on;
        bit drive_v;
        bit done = 1'b0;
        bit dec_on = 1'b0;
        int dec_start = 0;
        logic [9:0] dec_bits = '0;
        logic exp_line, exp_ready, exp_busy, act_line, act_ready, act_busy;
        int size_b;
        pend = stim_q;
        sent = stim_q;
        stall_o = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            frame_on  = (cur_start >= 0) && (cyc < cur_start + 10*div);
            exp_line  = frame_on ? frame_bit(cur_byte, (cyc - cur_start) / div) : 1'b1;
            exp_ready = (fifo_m.size() < depth);
            exp_busy  = prev_nonidle || prev_nonempty;
            act_line  = use2 ? l2 : l10;
            act_ready = use2 ? r2 : r10;
            act_busy  = use2 ? b2 : b10;
            total++;
            if (act_line !== exp_line)
                $display("FAIL %s line cyc=%0d got=%b want=%b", name, cyc, act_line, exp_line);
            else passed++;
            total++;
            if (act_ready !== exp_ready)
                $display("FAIL %s ready cyc=%0d got=%b want=%b", name, cyc, act_ready, exp_ready);
            else passed++;
            total++;
            if (act_busy !== exp_busy)
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, act_busy, exp_busy);
            else passed++;

            if (!dec_on && act_line === 1'b0) begin
                dec_on = 1'b1;
                dec_start = cyc;
            end
            if (dec_on && ((cyc - dec_start) % div == div / 2)) begin
                dec_bits[(cyc - dec_start) / div] = act_line;
                if ((cyc - dec_start) / div == 9) begin
                    dec_on = 1'b0;
                    total++;
                    if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1)
                        $display("FAIL %s framing got=%b want start=0 stop=1", name, dec_bits);
                    else passed++;
                    decoded.push_back(dec_bits[8:1]);
                end
            end

            drive_v = (pend.size() > 0) && ($urandom_range(99) >= gap_pct);
            tx_data = drive_v ? pend[0] : 8'($urandom);
            v10 = drive_v && !use2;
            v2  = drive_v && use2;
            if (drive_v && !act_ready) stall_o++;

            @(posedge clk);
            cyc++;
            size_b = fifo_m.size();
            prev_nonidle  = frame_on;
            prev_nonempty = (size_b > 0);
            if ((cur_start < 0 || cyc >= cur_start + 10*div) && size_b > 0) begin
                cur_byte  = fifo_m.pop_front();
                cur_start = cyc;
            end
            if (drive_v && size_b < depth)
                fifo_m.push_back(pend.pop_front());
            done = (pend.size() == 0) && (fifo_m.size() == 0) && (cur_start >= 0) &&
                   (cyc > cur_start + 10*div + 2);
        end
        @(negedge clk);
        v10 = 1'b0;
        v2  = 1'b0;
        total++;
        if (!done)
            $display("FAIL %s timeout got cyc=%0d want completion within budget", name, cyc);
        else passed++;
        total++;
        if (decoded.size() != sent.size())
            $display("FAIL %s byte_count got=%0d want=%0d", name, decoded.size(), sent.size());
        else passed++;
        for (int i = 0; i < decoded.size() && i < sent.size(); i++) begin
            total++;
            if (decoded[i] !== sent[i])
                $display("FAIL %s byte%0d got=%h want=%h", name, i, decoded[i], sent[i]);
            else passed++;
        end
        $display("%s: %0d bytes streamed, %0d stall cycles", name, sent.size(), stall_o);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({l10, r10, b10} !== 3'b110)
            $display("FAIL reset10 {line,ready,busy} got=%b want=110", {l10, r10, b10});
        else passed++;
        total++;
        if ({l2, r2, b2} !== 3'b110)
            $display("FAIL reset2 {line,ready,busy} got=%b want=110", {l2, r2, b2});
        else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: outputs checked during asynchronous reset");
    endtask

    task automatic test_single();
        int st;
        stim_q = {};
        stim_q.push_back(8'h55);
        run_stream("single", 1'b0, 0, 400, st);
    endtask

    task automatic test_back_to_back();
        int st;
        stim_q = {};
        stim_q.push_back(8'h55); stim_q.push_back(8'hAA); stim_q.push_back(8'h12);
        stim_q.push_back(8'h34); stim_q.push_back(8'h55); stim_q.push_back(8'hAA);
        run_stream("back_to_back", 1'b0, 0, 1500, st);
    endtask

    task automatic test_fifo_full();
        int st;
        stim_q = {};
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        run_stream("fifo_full", 1'b0, 0, 1500, st);
        // 6th push waits from after edge 5 until the first stop bit ends (edge 2+10*div).
        total++;
        if (st != 97)
            $display("FAIL fifo_full stall_cycles got=%0d want=97", st);
        else passed++;
    endtask

    task automatic test_min_divider();
        int st;
        stim_q = {};
        stim_q.push_back(8'hFF);
        stim_q.push_back(8'h00);
        run_stream("min_divider", 1'b1, 0, 200, st);
    endtask

    task automatic test_random();
        int st;
        for (int r = 0; r < 4; r++) begin
            stim_q = {};
            for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom));
            run_stream("random", r[0], 60, 3000, st);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        tx_data = 8'hA5;
        v10 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v10 = 1'b0;
        repeat (44) @(posedge clk);
        @(negedge clk);
        total++;
        if ({l10, b10} !== 2'b01)
            $display("FAIL midframe_bit3 {line,busy} got=%b want=01", {l10, b10});
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({l10, r10, b10} !== 3'b110)
            $display("FAIL midframe_reset {line,ready,busy} got=%b want=110", {l10, r10, b10});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            total++;
            if ({l10, b10} !== 2'b10)
                $display("FAIL midframe_idle cyc=%0d {line,busy} got=%b want=10", i, {l10, b10});
            else passed++;
        end
        $display("reset_mid_frame: line held high for 300 cycles after release");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_min_divider();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
